// File: rtl/car_tail_light_ctrl.sv
// car_tail_light_ctrl: tail-light sequencer for N_LAMP lamps per side.
// DIP-switch drive state and the brake pedal are synchronised, decoded
// into a registered drive-state FSM, and combined with slow (turn) and
// fast (hazard) blink timebases into registered lamp banks.
// Optional macro CAR_TAIL_SEQ_SWEEP_EN: turn blinks light the active bank
// progressively outward during the ON half instead of as a unit.
//
// state      | meaning
// -----------+-------------------------------------------------
// S_STRAIGHT | no turn; lamps follow brake
// S_LEFT     | left bank blinks on slow timebase, right follows brake
// S_RIGHT    | right bank blinks on slow timebase, left follows brake
// S_HAZARD   | both banks blink in phase on fast timebase, brake ignored
module car_tail_light_ctrl #(
   parameter int SLOW_HALF  = 6000000,
   parameter int FAST_HALF  = 1500000,
   parameter int N_LAMP     = 3,
   parameter int ACTIVE_LOW = 1,
   parameter int CNT_W      = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        sw,
   input  logic              brake,
   output logic [N_LAMP-1:0] left_lamp,
   output logic [N_LAMP-1:0] right_lamp,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_STRAIGHT = 2'd0,
      S_LEFT     = 2'd1,
      S_RIGHT    = 2'd2,
      S_HAZARD   = 2'd3
   } state_t;

   // Physical lamp pattern for "all off"; also the XOR mask applied to logical levels.
   localparam logic [N_LAMP-1:0] LAMP_POL = (ACTIVE_LOW != 0) ? {N_LAMP{1'b1}} : {N_LAMP{1'b0}};

   logic [3:0]        sw_s1, sw_s2;
   logic              brake_s1, brake_s2;
   state_t            state_q, state_nxt;
   logic              state_chg;
   logic [CNT_W-1:0]  slow_cnt, fast_cnt;
   logic              slow_phase, fast_phase;
   logic [N_LAMP-1:0] turn_on;
   logic [N_LAMP-1:0] left_nxt, right_nxt;

   // Two-flop synchronisers for the switch bank and brake pedal.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_s1    <= 4'b0000;
         sw_s2    <= 4'b0000;
         brake_s1 <= 1'b0;
         brake_s2 <= 1'b0;
      end else begin
         sw_s1    <= sw;
         sw_s2    <= sw_s1;
         brake_s1 <= brake;
         brake_s2 <= brake_s1;
      end
   end

   // Drive-state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_STRAIGHT;
      else      state_q <= state_nxt;
   end

   // Next-state decode; every switch code maps to a legal state.
   always_comb begin
      state_nxt = S_HAZARD;
      if (sw_s2[3:2] == 2'b00) begin
         case (sw_s2[1:0])
            2'b00:   state_nxt = S_STRAIGHT;
            2'b01:   state_nxt = S_LEFT;
            2'b10:   state_nxt = S_RIGHT;
            default: state_nxt = S_HAZARD;
         endcase
      end
   end

   assign state_chg = (state_nxt != state_q);

   // Slow timebase: runs only while turning; any state change restarts it lit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slow_cnt   <= '0;
         slow_phase <= 1'b1;
      end else if (state_chg || !(state_q == S_LEFT || state_q == S_RIGHT)) begin
         slow_cnt   <= '0;
         slow_phase <= 1'b1;
      end else if (slow_cnt == CNT_W'(SLOW_HALF - 1)) begin
         slow_cnt   <= '0;
         slow_phase <= ~slow_phase;
      end else begin
         slow_cnt   <= slow_cnt + CNT_W'(1);
      end
   end

   // Fast timebase: runs only in hazard; any state change restarts it lit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fast_cnt   <= '0;
         fast_phase <= 1'b1;
      end else if (state_chg || state_q != S_HAZARD) begin
         fast_cnt   <= '0;
         fast_phase <= 1'b1;
      end else if (fast_cnt == CNT_W'(FAST_HALF - 1)) begin
         fast_cnt   <= '0;
         fast_phase <= ~fast_phase;
      end else begin
         fast_cnt   <= fast_cnt + CNT_W'(1);
      end
   end

`ifdef CAR_TAIL_SEQ_SWEEP_EN
   localparam int STEP = SLOW_HALF / N_LAMP;

   // Sweep: lamp i joins once the slow count reaches i*STEP; dark in the OFF half.
   always_comb begin
      turn_on = '0;
      for (int i = 0; i < N_LAMP; i++) begin
         if (slow_phase && (slow_cnt >= CNT_W'(i * STEP))) turn_on[i] = 1'b1;
      end
   end
`else
   // Whole bank blinks as a unit.
   always_comb begin
      turn_on = {N_LAMP{slow_phase}};
   end
`endif

   // Output decode: logical lamp levels (1 = lit) for the current state.
   always_comb begin
      left_nxt  = '0;
      right_nxt = '0;
      case (state_q)
         S_STRAIGHT: begin
            left_nxt  = {N_LAMP{brake_s2}};
            right_nxt = {N_LAMP{brake_s2}};
         end
         S_LEFT: begin
            left_nxt  = turn_on;
            right_nxt = {N_LAMP{brake_s2}};
         end
         S_RIGHT: begin
            left_nxt  = {N_LAMP{brake_s2}};
            right_nxt = turn_on;
         end
         S_HAZARD: begin
            left_nxt  = {N_LAMP{fast_phase}};
            right_nxt = {N_LAMP{fast_phase}};
         end
         default: begin
            left_nxt  = '0;
            right_nxt = '0;
         end
      endcase
   end

   // Lamp registers hold the physical (polarity-corrected) drive levels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         left_lamp  <= LAMP_POL;
         right_lamp <= LAMP_POL;
      end else begin
         left_lamp  <= left_nxt ^ LAMP_POL;
         right_lamp <= right_nxt ^ LAMP_POL;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_car_tail_light_ctrl.sv
// Bench for car_tail_light_ctrl: two instances (active-high and active-low
// lamps) share stimulus; expected per-cycle lamp/state values are queued by
// the stimulus and compared by an independent negedge monitor.
module tb_car_tail_light_ctrl;

   localparam int SH = 12;
   localparam int FH = 3;
   localparam int N  = 3;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic [3:0] sw    = 4'b0000;
   logic       brake = 1'b0;
   logic [N-1:0] l1, r1, l2, r2;
   logic [1:0]   st1, st2;

   car_tail_light_ctrl #(.SLOW_HALF(SH), .FAST_HALF(FH), .N_LAMP(N), .ACTIVE_LOW(0), .CNT_W(24)) dut_hi (
      .clk(clk), .rst(rst), .sw(sw), .brake(brake),
      .left_lamp(l1), .right_lamp(r1), .state(st1));

   car_tail_light_ctrl #(.SLOW_HALF(SH), .FAST_HALF(FH), .N_LAMP(N), .ACTIVE_LOW(1), .CNT_W(24)) dut_lo (
      .clk(clk), .rst(rst), .sw(sw), .brake(brake),
      .left_lamp(l2), .right_lamp(r2), .state(st2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         tag;
      logic [2:0] l;
      logic [2:0] r;
      logic [1:0] st;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic void push(int c, int tag, logic [2:0] l, logic [2:0] r, logic [1:0] st);
      exp_t e;
      int idx;
      e.cyc = c; e.tag = tag; e.l = l; e.r = r; e.st = st;
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > c) idx--;
      sb.insert(idx, e);
   endfunction

   // Logical mask of the blinking bank at offset o within the ON half.
   function automatic logic [2:0] on_mask(int o);
`ifdef CAR_TAIL_SEQ_SWEEP_EN
      if (o < 4)      return 3'b001;
      else if (o < 8) return 3'b011;
      else            return 3'b111;
`else
      return 3'b111;
`endif
   endfunction

   task automatic chk(string name, int tag, int c, logic [2:0] got, logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s scen=%0d cyc=%0d got=%b exp=%b", name, tag, c, got, exp);
      end
   endtask

   // Monitor: compares both instances against the queued expectation for this cycle.
   exp_t me;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         me = sb.pop_front();
         if (me.cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_check scen=%0d cyc=%0d got=none exp=cyc%0d", me.tag, cyc, me.cyc);
         end else begin
            chk("left_hi",  me.tag, cyc, l1, me.l);
            chk("right_hi", me.tag, cyc, r1, me.r);
            chk("state_hi", me.tag, cyc, {1'b0, st1}, {1'b0, me.st});
            chk("left_lo",  me.tag, cyc, l2, ~me.l);
            chk("right_lo", me.tag, cyc, r2, ~me.r);
            chk("state_lo", me.tag, cyc, {1'b0, st2}, {1'b0, me.st});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   initial begin
      int p, q, h, x, r0, o;
      logic [2:0] lv, rv;
      logic [1:0] sv;

      // Reset values.
      tick(); tick();
      push(cyc, 0, 3'b000, 3'b000, 2'd0);
      tick();
      rst = 1'b1;
      tick(); tick();

      // Straight: brake on/off latency.
      p = cyc;
      brake = 1'b1;
      for (int c = p + 1; c <= p + 5; c++)
         push(c, 1, (c >= p + 3) ? 3'b111 : 3'b000, (c >= p + 3) ? 3'b111 : 3'b000, 2'd0);
      wait_until(p + 5);
      q = cyc;
      brake = 1'b0;
      for (int c = q + 1; c <= q + 4; c++)
         push(c, 2, (c >= q + 3) ? 3'b000 : 3'b111, (c >= q + 3) ? 3'b000 : 3'b111, 2'd0);
      wait_until(q + 4);

      // Left blink, brake on the idle side from p+30 to p+44.
      p = cyc;
      sw = 4'b0001;
      for (int c = p + 1; c <= p + 44; c++) begin
         sv = (c >= p + 3) ? 2'd1 : 2'd0;
         lv = 3'b000;
         if (c >= p + 4) begin
            o = (c - p - 4) % 24;
            if (o < 12) lv = on_mask(o);
         end
         rv = (c >= p + 33) ? 3'b111 : 3'b000;
         push(c, 3, lv, rv, sv);
      end
      wait_until(p + 30);
      brake = 1'b1;
      wait_until(p + 44);
      brake = 1'b0;
      wait_until(p + 45);

      // Mid-OFF switch to right: restart lit.
      sw = 4'b0010;
      for (int c = p + 45; c <= p + 65; c++) begin
         sv = (c >= p + 48) ? 2'd2 : 2'd1;
         rv = (c <= p + 46) ? 3'b111 : 3'b000;
         if (c >= p + 49 && c <= p + 60) rv = on_mask(c - p - 49);
         push(c, 4, 3'b000, rv, sv);
      end
      wait_until(p + 65);

      // Hazard from 0011 then 0100, brake asserted midway (ignored).
      h = cyc;
      sw = 4'b0011;
      for (int c = h + 1; c <= h + 33; c++) begin
         sv = (c >= h + 3) ? 2'd3 : 2'd2;
         lv = 3'b000;
         if (c >= h + 4 && ((c - h - 4) / 3) % 2 == 0) lv = 3'b111;
         push(c, 5, lv, lv, sv);
      end
      wait_until(h + 8);
      brake = 1'b1;
      wait_until(h + 20);
      sw = 4'b0100;
      wait_until(h + 34);

      // Async reset during a lit hazard half, then restart into left blink.
      x = cyc;
      rst = 1'b0;
      sw = 4'b0001;
      brake = 1'b0;
      for (int c = x; c <= x + 3; c++) push(c, 6, 3'b000, 3'b000, 2'd0);
      wait_until(x + 3);
      rst = 1'b1;
      r0 = cyc;
      for (int c = r0 + 1; c <= r0 + 18; c++) begin
         sv = (c >= r0 + 3) ? 2'd1 : 2'd0;
         lv = 3'b000;
         if (c >= r0 + 4 && c <= r0 + 15) lv = on_mask(c - r0 - 4);
         push(c, 7, lv, 3'b000, sv);
      end
      wait_until(r0 + 20);

      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      while (sb.size() > 0) begin
         me = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL unchecked scen=%0d got=none exp=cyc%0d", me.tag, me.cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/car_tail_light_ctrl.md
Name: car_tail_light_ctrl

Overview:
- Parametrised tail-light controller: N lamps per side, a registered drive-state FSM, separate slow and fast blink timebases, and a brake override.
- Takes raw DIP-switch state and a brake input.
- Drives left and right lamp banks plus a 2-bit state code for the status display (7-seg/LED).
- Sits between the board switches and the tricolour/single LED outputs.

Parameters:
- SLOW_HALF, 6000000: clk cycles per half-period of the turn blink (on time = off time = SLOW_HALF).
- FAST_HALF, 1500000: clk cycles per half-period of the hazard blink.
- N_LAMP, 3: lamps per side, range 1..8.
- ACTIVE_LOW, 1: 1 = lamp on drives 0; 0 = lamp on drives 1.
- CNT_W, 24: width of the blink counters; must hold SLOW_HALF-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- sw  input  4  drive state: 0000 straight, 0001 left, 0010 right, 0011 stop/fault; any value with sw[3:2]!=0 is treated as fault
- brake  input  1  brake pedal, level, asynchronous to clk
- left_lamp  output  N_LAMP  left bank; bit 0 is the innermost lamp
- right_lamp  output  N_LAMP  right bank; bit 0 is the innermost lamp
- state  output  2  registered FSM code: 0 straight, 1 left, 2 right, 3 hazard

Behaviour:
- Reset (rst=0, async):
  - state=0, counters=0, phase=ON, synchronisers cleared.
  - All lamps off: all ones if ACTIVE_LOW=1, zeros otherwise.
- Inputs: sw and brake each pass through a 2-flop synchroniser.
  - FSM state updates on the cycle after the synchronised value arrives, so sw change -> state change takes 3 clk edges.
  - Lamps are registered and follow state by 1 further cycle.
- FSM states and next-state decode (taken from any state; no illegal states reachable):
  - S_STRAIGHT: synced sw == 0000
  - S_LEFT: synced sw == 0001
  - S_RIGHT: synced sw == 0010
  - S_HAZARD: synced sw == 0011, or sw[3:2] != 0
- On any state change, in the same edge: slow and fast counters clear to 0 and phase is set to ON. A new pattern always starts lit.
- Slow timebase:
  - Counter runs 0..SLOW_HALF-1, then wraps to 0 and toggles slow_phase.
  - Runs only in S_LEFT and S_RIGHT; held at 0 otherwise.
- Fast timebase:
  - Counter runs 0..FAST_HALF-1, then wraps and toggles fast_phase.
  - Runs only in S_HAZARD.
- Lamp logic, logical on=1 before the polarity stage:
  - S_STRAIGHT: both banks off; brake=1 -> both banks all on.
  - S_LEFT: left bank = slow_phase ? all on : all off. Right bank off; brake=1 -> right bank all on. The blinking side ignores brake.
  - S_RIGHT: mirror of S_LEFT.
  - S_HAZARD: both banks = fast_phase ? all on : all off, in phase. Brake is ignored.
- Polarity: final outputs are inverted when ACTIVE_LOW=1.
- brake changes do not reset the counters.
- Reset asserted mid-blink: outputs go off immediately (async). After release, the first pattern starts at phase ON from count 0.

Optional Feature:
- Macro: CAR_TAIL_SEQ_SWEEP_EN
- Defined: during the ON half of a turn blink, the active bank lights progressively.
  - STEP = SLOW_HALF / N_LAMP (integer division).
  - At slow count c, lamps [0..k] are lit, where k = min(N_LAMP-1, c/STEP).
  - Lit lamps accumulate outward from bit 0; the outermost lamp lights no later than count (N_LAMP-1)*STEP.
  - OFF half: whole bank dark.
  - Hazard and brake behaviour unchanged.
- Undefined: the whole bank blinks as a unit; no sweep logic is synthesised.

Test Plan:
(All scenarios use SLOW_HALF=12, FAST_HALF=3, N_LAMP=3, ACTIVE_LOW=0 unless stated.)
- Reset, sw=0000, brake=0 -> lamps 000/000, state=0. Set brake=1 -> both banks 111 exactly 3 cycles later. Drop brake -> both banks 000 3 cycles after the drop.
- sw 0000->0001 -> state=1 after 3 edges. Left bank 111 for 12 cycles, then 000 for 12 cycles, repeating; right bank 000 throughout. Assert brake -> right bank 111; left bank blink period unchanged.
- sw=0011, then sw=0100 -> both banks toggle 111/000 every 3 cycles, in phase, state=3. Brake=1 has no effect on either case.
- Mid-OFF-phase of a left blink, switch to 0010 -> right bank 111 the cycle after state=2, count restarted; left bank 000.
- ACTIVE_LOW=1 -> reset gives 111/111; straight with brake gives 000/000.
- With CAR_TAIL_SEQ_SWEEP_EN defined (STEP=4), sw=0001 -> left bank 001 for counts 0-3, 011 for 4-7, 111 for 8-11, then 000 for 12 cycles.
